mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 The parameters SHALL be:
- MULT_LAT, default 5, busy cycles for mult/multu.
- DIV_LAT, default 10, busy cycles for div/divu.
REQ-002 The ports SHALL be, clock and reset first:
- clk  in  1  rising-edge clock; the only clock in the block.
- reset  in  1  asynchronous, active-high reset.
- MDUop  in  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 mean none.
- rs  in  32  first operand (dividend, or source for mthi/mtlo).
- rt  in  32  second operand (divisor).
- start  out  1  combinational; high when a mult/multu/div/divu is accepted this cycle.
- busy  out  1  registered; high while an operation is in flight.
- MDUout  out  32  combinational; HI when MDUop=7, LO when MDUop=8, else 0.

Function
REQ-003 Accept condition: a mult/multu/div/divu is accepted when busy=0; the operands are latched at that clock edge.
REQ-004 start SHALL equal (MDUop in 1..4) AND NOT busy.
REQ-005 Busy timing: busy SHALL rise at the edge that accepts the operation and stay high for exactly MULT_LAT (mult) or DIV_LAT (div) cycles, counted by an internal down-counter.
REQ-006 Result write: HI/LO SHALL update at the edge that ends the last busy cycle; busy is 0 in the following cycle.
REQ-007 mult: {HI,LO} SHALL be the signed 64-bit product of rs and rt.
REQ-008 multu: {HI,LO} SHALL be the unsigned 64-bit product of rs and rt.
REQ-009 div: LO SHALL be the signed quotient, truncated toward zero; HI SHALL be the remainder, with the sign of the dividend.
REQ-010 divu: LO SHALL be the unsigned quotient and HI the unsigned remainder.
REQ-011 Divide by zero (rt=0 on div/divu): the operation SHALL still run DIV_LAT busy cycles, and HI and LO SHALL be left unchanged.
REQ-012 Signed overflow: div of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-013 mthi/mtlo: when busy=0, HI (resp. LO) SHALL take rs at the next edge, with no busy cycles.
REQ-014 Ops while busy: any mult/div/mthi/mtlo presented while busy=1 SHALL be ignored, with no state change. Upstream stalls on (busy OR start) when the instruction uses the MDU.
REQ-015 mfhi/mflo SHALL return the current HI/LO register value combinationally. The returned value is architecturally valid only when busy=0.
REQ-016 Back-to-back: a new operation presented in the first cycle with busy=0 after completion SHALL be accepted and SHALL see the updated HI/LO.
REQ-017 Multiply implementation: the product SHALL be computed combinationally at accept and held in a pipeline register until commit; it SHALL NOT be computed iteratively.
REQ-018 Divide implementation: division MAY be computed at accept and held in the same way. Observable latency SHALL be set only by the counter.

Reset
REQ-019 When reset is asserted, HI, LO, the counter, the latched results and busy SHALL all clear to 0 asynchronously.
REQ-020 Reset mid-operation SHALL discard the in-flight result; HI/LO SHALL stay 0 after reset is released.
REQ-021 On the first edge after reset is released, the block SHALL be idle and ready to accept an operation.

Structure
REQ-022 A shared package SHALL hold:
- the MDUop encodings (MDU_NONE..MDU_MFLO), alongside the existing ALUop encodings;
- the default latency constants.
REQ-023 The design SHALL consist of a single module with no sub-modules.
REQ-024 Widths SHALL be 32-bit operands and 64-bit intermediate product, with 6-bit counter width minimum.

Verification
REQ-025 mult with rs=0xFFFFFFFF (-1), rt=2 -> start=1 for one cycle, busy=1 for 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFE.
REQ-026 multu with rs=0xFFFFFFFF, rt=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
REQ-027 div with rs=-7, rt=2 -> busy for 10 cycles, then LO=0xFFFFFFFD (-3) and HI=0xFFFFFFFF (-1). divu with rs=7, rt=2 -> LO=3, HI=1.
REQ-028 mthi 0x12345678, then div with rt=0 -> busy for 10 cycles, HI stays 0x12345678, and mfhi returns 0x12345678.
REQ-029 mtlo 0xAAAA presented while a mult is busy -> ignored; LO holds the mult result afterwards.
REQ-030 reset asserted in busy cycle 3 of a mult -> busy=0 and HI=LO=0 immediately; no commit occurs later.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared CPU definitions: ALU and MDU operation encodings,
// plus the default multiply/divide latencies.
package mdu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8
    } mdu_op_e;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;
    localparam int CNT_W_MIN    = 6;

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers and fixed latency.
// Ports: clk, reset (async high), MDUop, rs, rt -> start, busy, MDUout.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUop,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        start,
    output logic        busy,
    output logic [31:0] MDUout
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_REQ = $clog2(MAX_LAT + 1);
    localparam int CNT_W   = (CNT_REQ > CNT_W_MIN) ? CNT_REQ : CNT_W_MIN;

    logic [31:0]      hi, lo;
    logic [31:0]      res_hi, res_lo;
    logic             res_wr;
    logic [CNT_W-1:0] cnt;

    logic is_mult, is_multu, is_div, is_divu;
    logic is_mthi, is_mtlo, is_long;

    always_comb begin
        is_mult  = (MDUop == MDU_MULT);
        is_multu = (MDUop == MDU_MULTU);
        is_div   = (MDUop == MDU_DIV);
        is_divu  = (MDUop == MDU_DIVU);
        is_mthi  = (MDUop == MDU_MTHI);
        is_mtlo  = (MDUop == MDU_MTLO);
        is_long  = is_mult | is_multu | is_div | is_divu;
    end

    assign start = is_long & ~busy;

    // Products are formed in one shot and parked until commit.
    logic [63:0] prod_s, prod_u;
    assign prod_s = $signed({{32{rs[31]}}, rs})
                  * $signed({{32{rt[31]}}, rt});
    assign prod_u = {32'd0, rs} * {32'd0, rt};

    // A zero divisor is swapped for 1 so the dividers never see it;
    // that result is discarded anyway.
    logic [31:0] dvs;
    logic [31:0] a_mag, b_mag, uq, ur;
    logic [31:0] q_s, r_s, q_u, r_u;

    always_comb begin
        dvs   = (rt == 32'd0) ? 32'd1 : rt;
        a_mag = rs[31] ? (~rs + 32'd1) : rs;
        b_mag = dvs[31] ? (~dvs + 32'd1) : dvs;
        uq    = a_mag / b_mag;
        ur    = a_mag % b_mag;
        // Negating 0x80000000 wraps to itself, which gives the
        // required overflow result without a special case.
        q_s   = (rs[31] ^ dvs[31]) ? (~uq + 32'd1) : uq;
        r_s   = rs[31] ? (~ur + 32'd1) : ur;
        q_u   = rs / dvs;
        r_u   = rs % dvs;
    end

    logic [31:0]      nxt_hi, nxt_lo;
    logic             nxt_wr;
    logic [CNT_W-1:0] nxt_lat;

    always_comb begin
        nxt_hi  = '0;
        nxt_lo  = '0;
        nxt_wr  = 1'b0;
        nxt_lat = CNT_W'(DIV_LAT);
        unique case (1'b1)
            is_mult: begin
                {nxt_hi, nxt_lo} = prod_s;
                nxt_wr  = 1'b1;
                nxt_lat = CNT_W'(MULT_LAT);
            end
            is_multu: begin
                {nxt_hi, nxt_lo} = prod_u;
                nxt_wr  = 1'b1;
                nxt_lat = CNT_W'(MULT_LAT);
            end
            is_div: begin
                nxt_hi = r_s;
                nxt_lo = q_s;
                nxt_wr = (rt != 32'd0);
            end
            is_divu: begin
                nxt_hi = r_u;
                nxt_lo = q_u;
                nxt_wr = (rt != 32'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi     <= '0;
            lo     <= '0;
            res_hi <= '0;
            res_lo <= '0;
            res_wr <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (busy) begin
            if (cnt == CNT_W'(1)) begin
                busy <= 1'b0;
                cnt  <= '0;
                if (res_wr) begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= nxt_lat;
            res_hi <= nxt_hi;
            res_lo <= nxt_lo;
            res_wr <= nxt_wr;
        end else if (is_mthi) begin
            hi <= rs;
        end else if (is_mtlo) begin
            lo <= rs;
        end
    end

    always_comb begin
        MDUout = '0;
        if (MDUop == MDU_MFHI)
            MDUout = hi;
        else if (MDUop == MDU_MFLO)
            MDUout = lo;
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed vectors plus randomized
// operations compared against an arithmetic HI/LO model.
module tb_mdu;
    import mdu_pkg::*;

    localparam int ML = 5;
    localparam int DL = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  MDUop;
    logic [31:0] rs, rt;
    logic        start, busy;
    logic [31:0] MDUout;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_hi, m_lo;

    mdu #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk(clk),
        .reset(reset),
        .MDUop(MDUop),
        .rs(rs),
        .rt(rt),
        .start(start),
        .busy(busy),
        .MDUout(MDUout)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Architectural model: what HI/LO must hold after an op.
    function automatic void model(input logic [3:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  output int lat);
        longint sa, sb, p, q, r;
        logic [63:0] pu;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lat = 0;
        case (op)
            MDU_MULT: begin
                p = sa * sb;
                m_hi = p[63:32];
                m_lo = p[31:0];
                lat = ML;
            end
            MDU_MULTU: begin
                pu = 64'(a) * 64'(b);
                m_hi = pu[63:32];
                m_lo = pu[31:0];
                lat = ML;
            end
            MDU_DIV: begin
                if (b != 0) begin
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
                lat = DL;
            end
            MDU_DIVU: begin
                if (b != 0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
                lat = DL;
            end
            MDU_MTHI: m_hi = a;
            MDU_MTLO: m_lo = a;
            default: ;
        endcase
    endfunction

    // Present an op for one cycle, then count busy cycles.
    task automatic run_op(input logic [3:0] op,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          output logic st,
                          output int ncyc);
        MDUop = op;
        rs = a;
        rt = b;
        #1;
        st = start;
        @(posedge clk);
        #1;
        MDUop = MDU_NONE;
        rs = $urandom;
        rt = $urandom;
        ncyc = 0;
        while (busy === 1'b1 && ncyc < 200) begin
            ncyc++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic read_hilo(output logic [31:0] h,
                             output logic [31:0] l);
        logic [3:0] sv;
        sv = MDUop;
        MDUop = MDU_MFHI;
        #1 h = MDUout;
        MDUop = MDU_MFLO;
        #1 l = MDUout;
        MDUop = sv;
        #1;
    endtask

    task automatic test_reset;
        logic [31:0] h, l;
        logic st;
        int n, lat;
        reset = 1'b1;
        MDUop = MDU_NONE;
        rs = 0;
        rt = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        read_hilo(h, l);
        checks++;
        if (h !== 0 || l !== 0) begin
            failures++;
            $display("FAIL reset_hilo: got %h/%h expected 0/0", h, l);
        end
        m_hi = 0;
        m_lo = 0;
        @(negedge clk);
        reset = 1'b0;
        run_op(MDU_MULT, 32'd3, 32'd4, st, n);
        model(MDU_MULT, 32'd3, 32'd4, lat);
        checks++;
        if (st !== 1'b1 || n != ML) begin
            failures++;
            $display("FAIL first_accept: got start=%b cyc=%0d expected 1/%0d",
                     st, n, ML);
        end
        read_hilo(h, l);
        checks++;
        if (h !== 0 || l !== 32'd12) begin
            failures++;
            $display("FAIL first_result: got %h/%h expected 0/0000000c", h, l);
        end
    endtask

    task automatic test_mult_vectors;
        logic [31:0] h, l;
        logic st;
        int n, lat;
        run_op(MDU_MULT, 32'hFFFFFFFF, 32'd2, st, n);
        model(MDU_MULT, 32'hFFFFFFFF, 32'd2, lat);
        read_hilo(h, l);
        checks++;
        if (st !== 1'b1 || n != ML) begin
            failures++;
            $display("FAIL mult_timing: got start=%b cyc=%0d expected 1/%0d",
                     st, n, ML);
        end
        checks++;
        if (h !== 32'hFFFFFFFF || l !== 32'hFFFFFFFE) begin
            failures++;
            $display("FAIL mult_neg: got %h/%h expected ffffffff/fffffffe", h, l);
        end
        run_op(MDU_MULTU, 32'hFFFFFFFF, 32'd2, st, n);
        model(MDU_MULTU, 32'hFFFFFFFF, 32'd2, lat);
        read_hilo(h, l);
        checks++;
        if (n != ML || h !== 32'h1 || l !== 32'hFFFFFFFE) begin
            failures++;
            $display("FAIL multu: got cyc=%0d %h/%h expected %0d 00000001/fffffffe",
                     n, h, l, ML);
        end
    endtask

    task automatic test_div_vectors;
        logic [31:0] h, l;
        logic st;
        int n, lat;
        run_op(MDU_DIV, -32'sd7, 32'd2, st, n);
        model(MDU_DIV, -32'sd7, 32'd2, lat);
        read_hilo(h, l);
        checks++;
        if (st !== 1'b1 || n != DL) begin
            failures++;
            $display("FAIL div_timing: got start=%b cyc=%0d expected 1/%0d",
                     st, n, DL);
        end
        checks++;
        if (h !== 32'hFFFFFFFF || l !== 32'hFFFFFFFD) begin
            failures++;
            $display("FAIL div_neg: got %h/%h expected ffffffff/fffffffd", h, l);
        end
        run_op(MDU_DIVU, 32'd7, 32'd2, st, n);
        model(MDU_DIVU, 32'd7, 32'd2, lat);
        read_hilo(h, l);
        checks++;
        if (n != DL || h !== 32'd1 || l !== 32'd3) begin
            failures++;
            $display("FAIL divu: got cyc=%0d %h/%h expected %0d 1/3", n, h, l, DL);
        end
        run_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, st, n);
        model(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, lat);
        read_hilo(h, l);
        checks++;
        if (h !== 32'd0 || l !== 32'h80000000) begin
            failures++;
            $display("FAIL div_ovf: got %h/%h expected 0/80000000", h, l);
        end
    endtask

    task automatic test_div_zero;
        logic [31:0] h, l;
        logic st;
        int n, lat;
        run_op(MDU_MTHI, 32'h12345678, 32'd0, st, n);
        model(MDU_MTHI, 32'h12345678, 32'd0, lat);
        checks++;
        if (st !== 1'b0 || n != 0) begin
            failures++;
            $display("FAIL mthi_timing: got start=%b cyc=%0d expected 0/0", st, n);
        end
        run_op(MDU_DIV, 32'd99, 32'd0, st, n);
        model(MDU_DIV, 32'd99, 32'd0, lat);
        read_hilo(h, l);
        checks++;
        if (n != DL) begin
            failures++;
            $display("FAIL divz_timing: got cyc=%0d expected %0d", n, DL);
        end
        checks++;
        if (h !== 32'h12345678 || l !== m_lo) begin
            failures++;
            $display("FAIL divz_hold: got %h/%h expected 12345678/%h", h, l, m_lo);
        end
        run_op(MDU_DIVU, 32'd5, 32'd0, st, n);
        model(MDU_DIVU, 32'd5, 32'd0, lat);
        read_hilo(h, l);
        checks++;
        if (n != DL || h !== m_hi || l !== m_lo) begin
            failures++;
            $display("FAIL divuz_hold: got cyc=%0d %h/%h expected %0d %h/%h",
                     n, h, l, DL, m_hi, m_lo);
        end
    endtask

    task automatic test_ignore_while_busy;
        logic [31:0] h, l;
        int n, lat;
        logic st_mul;
        MDUop = MDU_MULT;
        rs = 32'd123457;
        rt = -32'sd9;
        #1;
        model(MDU_MULT, 32'd123457, -32'sd9, lat);
        @(posedge clk);
        #1;
        n = 1;
        MDUop = MDU_MTLO;
        rs = 32'hAAAA;
        @(posedge clk);
        #1;
        n++;
        MDUop = MDU_MULT;
        rs = 32'd7;
        rt = 32'd7;
        #1 st_mul = start;
        checks++;
        if (st_mul !== 1'b0) begin
            failures++;
            $display("FAIL busy_start: got %b expected 0", st_mul);
        end
        @(posedge clk);
        #1;
        n++;
        MDUop = MDU_MTHI;
        rs = 32'h5555;
        @(posedge clk);
        #1;
        n++;
        MDUop = MDU_NONE;
        while (busy === 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != ML + 1) begin
            failures++;
            $display("FAIL busy_len: got %0d expected %0d", n - 1, ML);
        end
        read_hilo(h, l);
        checks++;
        if (h !== m_hi || l !== m_lo) begin
            failures++;
            $display("FAIL busy_ignore: got %h/%h expected %h/%h", h, l, m_hi, m_lo);
        end
    endtask

    task automatic test_reset_mid_op;
        logic [31:0] h, l;
        MDUop = MDU_MULTU;
        rs = 32'hDEADBEEF;
        rt = 32'h1234;
        @(posedge clk);
        #1;
        MDUop = MDU_NONE;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_busy: got %b expected 0", busy);
        end
        read_hilo(h, l);
        checks++;
        if (h !== 0 || l !== 0) begin
            failures++;
            $display("FAIL rst_mid_hilo: got %h/%h expected 0/0", h, l);
        end
        m_hi = 0;
        m_lo = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (ML + 3) @(posedge clk);
        #1;
        read_hilo(h, l);
        checks++;
        if (busy !== 1'b0 || h !== 0 || l !== 0) begin
            failures++;
            $display("FAIL rst_no_commit: got busy=%b %h/%h expected 0 0/0",
                     busy, h, l);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] h, l;
        logic st;
        int n, lat;
        run_op(MDU_MULTU, 32'h10001, 32'h30003, st, n);
        model(MDU_MULTU, 32'h10001, 32'h30003, lat);
        run_op(MDU_MTLO, 32'hCAFEF00D, 32'd0, st, n);
        model(MDU_MTLO, 32'hCAFEF00D, 32'd0, lat);
        read_hilo(h, l);
        checks++;
        if (h !== m_hi || l !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL b2b_mtlo: got %h/%h expected %h/cafef00d", h, l, m_hi);
        end
        run_op(MDU_DIVU, 32'd1000, 32'd7, st, n);
        model(MDU_DIVU, 32'd1000, 32'd7, lat);
        checks++;
        if (st !== 1'b1 || n != DL) begin
            failures++;
            $display("FAIL b2b_accept: got start=%b cyc=%0d expected 1/%0d",
                     st, n, DL);
        end
        read_hilo(h, l);
        checks++;
        if (h !== 32'd6 || l !== 32'd142) begin
            failures++;
            $display("FAIL b2b_divu: got %h/%h expected 6/8e", h, l);
        end
    endtask

    task automatic test_random;
        logic [31:0] h, l, a, b;
        logic [3:0] op;
        logic st;
        int n, lat, sel;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(1, 6));
            a = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0)
                b = 0;
            else if (sel == 1)
                b = $urandom_range(1, 9);
            else if (sel == 2)
                b = 32'hFFFFFFFF;
            else
                b = $urandom;
            if (sel == 2 && i % 3 == 0)
                a = 32'h80000000;
            run_op(op, a, b, st, n);
            model(op, a, b, lat);
            read_hilo(h, l);
            checks++;
            if (st !== (op <= 4'd4)) begin
                failures++;
                $display("FAIL rnd_start[%0d] op=%0d: got %b expected %b",
                         i, op, st, (op <= 4'd4));
            end
            checks++;
            if (n != lat) begin
                failures++;
                $display("FAIL rnd_lat[%0d] op=%0d: got %0d expected %0d",
                         i, op, n, lat);
            end
            checks++;
            if (h !== m_hi) begin
                failures++;
                $display("FAIL rnd_hi[%0d] op=%0d a=%h b=%h: got %h expected %h",
                         i, op, a, b, h, m_hi);
            end
            checks++;
            if (l !== m_lo) begin
                failures++;
                $display("FAIL rnd_lo[%0d] op=%0d a=%h b=%h: got %h expected %h",
                         i, op, a, b, l, m_lo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult_vectors();
        test_div_vectors();
        test_div_zero();
        test_ignore_while_busy();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
